// File: rtl/data_mem_pkg.sv
// Shared micro-op encodings and data memory FSM state type.
// Included by the LSU-side memory blocks and their benches.
package data_mem_pkg;

  localparam logic [4:0] LDR  = 5'h01;
  localparam logic [4:0] STR  = 5'h02;
  localparam logic [4:0] LDRB = 5'h0A;
  localparam logic [4:0] STRB = 5'h0B;

  typedef enum logic {DM_INIT, DM_IDLE} dm_state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_WIDTH storage, one byte-enabled write port, registered read port.
// Read data appears the cycle after i_re; contents are not reset.
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                     i_clock,
  input  logic [DATA_WIDTH/8-1:0]  i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdat,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdat
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdat;

  always_ff @(posedge i_clock) begin
    for (int b = 0; b < NB; b++) begin
      if (i_we[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdat[b*8 +: 8];
    end
    if (i_re) r_rdat <= r_mem[i_raddr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/data_mem.sv
// Load/store data memory with post-reset hardware clear; 1-cycle response latency.
// req_ready is low while clearing, otherwise one request per cycle with no stall.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH) + $clog2(DATA_WIDTH/8)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            uop,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LB  = $clog2(NB);
  localparam int WAW = $clog2(DEPTH);

  dm_state_t r_state, w_state_nxt;
  logic [WAW-1:0] r_clr_idx, w_clr_idx_nxt;

  logic w_accept, w_is_ld, w_is_st, w_is_ldrb, w_is_strb, w_mem_op, w_misalign;
  logic [LB-1:0]  w_lane;
  logic [WAW-1:0] w_widx;

  logic [NB-1:0]         w_we;
  logic [WAW-1:0]        w_waddr;
  logic [DATA_WIDTH-1:0] w_wdat, w_rdat, w_load_val;
  logic [7:0]            w_byte;

  logic                  r_rsp_valid, r_rsp_err, r_rsp_load, r_rsp_byte;
  logic [LB-1:0]         r_rsp_lane;
  logic [DATA_WIDTH-1:0] r_data_hold;

  assign w_lane     = addr[LB-1:0];
  assign w_widx     = addr[LB +: WAW];
  assign w_is_ld    = (uop == LDR);
  assign w_is_st    = (uop == STR);
  assign w_is_ldrb  = (uop == LDRB);
  assign w_is_strb  = (uop == STRB);
  assign w_mem_op   = w_is_ld | w_is_st | w_is_ldrb | w_is_strb;
  assign w_misalign = (w_lane != '0);
  // A request coinciding with reset is dropped even though req_ready is still high.
  assign w_accept   = req_valid & req_ready & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= DM_INIT;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    req_ready     = 1'b0;
    case (r_state)
      DM_INIT: begin
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == WAW'(DEPTH - 1)) w_state_nxt = DM_IDLE;
      end
      DM_IDLE: req_ready = 1'b1;
      default: w_state_nxt = DM_INIT;
    endcase
  end

  // Clear writes own the port during INIT; stores only reach it from IDLE.
  always_comb begin
    w_we    = '0;
    w_waddr = w_widx;
    w_wdat  = data_in;
    if (!reset && r_state == DM_INIT) begin
      w_we    = '1;
      w_waddr = r_clr_idx;
      w_wdat  = '0;
    end else if (w_accept && w_is_st && !w_misalign) begin
      w_we = '1;
    end else if (w_accept && w_is_strb) begin
      w_we   = NB'(1) << w_lane;
      w_wdat = {NB{data_in[7:0]}};
    end
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .i_clock (clock),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdat  (w_wdat),
    .i_re    (w_accept & (w_is_ld | w_is_ldrb)),
    .i_raddr (w_widx),
    .o_rdat  (w_rdat)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_load  <= 1'b0;
      r_rsp_byte  <= 1'b0;
      r_rsp_lane  <= '0;
      r_data_hold <= '0;
    end else begin
      r_rsp_valid <= w_accept & w_mem_op;
      r_rsp_err   <= w_accept & (w_is_ld | w_is_st) & w_misalign;
      if (w_accept && w_mem_op) begin
        r_rsp_load <= w_is_ld | w_is_ldrb;
        r_rsp_byte <= w_is_ldrb;
        r_rsp_lane <= w_lane;
      end
      if (r_rsp_valid && r_rsp_load) r_data_hold <= w_load_val;
    end
  end

  assign w_byte = w_rdat[{r_rsp_lane, 3'b000} +: 8];

  always_comb begin
    w_load_val = w_rdat;
    if (r_rsp_err)       w_load_val = '0;
    else if (r_rsp_byte) w_load_val = {{(DATA_WIDTH-8){1'b0}}, w_byte};
  end

  // Array read data is only valid in the response cycle; afterwards the held copy is shown.
  assign data_out  = (r_rsp_valid && r_rsp_load) ? w_load_val : r_data_hold;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: clear timing, word/byte access, misalignment, NOPs, resets.
module tb_data_mem;
  import data_mem_pkg::*;

  localparam logic [4:0] NOP = 5'h00;

  logic        clock = 1'b0;
  logic        reset, req_valid, req_ready, rsp_valid, rsp_err;
  logic [4:0]  uop;
  logic [6:0]  addr;
  logic [31:0] data_in, data_out;

  int n_pass = 0;
  int n_tot  = 0;

  data_mem dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .uop       (uop),
    .addr      (addr),
    .data_in   (data_in),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .data_out  (data_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        vld;
    logic [4:0]  op;
    logic [6:0]  a;
    logic [31:0] din;
    logic        e_vld;
    logic        e_err;
    logic [31:0] e_dout;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic v, input logic [4:0] o, input logic [6:0] a,
                              input logic [31:0] d, input logic ev, input logic ee,
                              input logic [31:0] ed);
    vec_t t;
    t.vld = v; t.op = o; t.a = a; t.din = d; t.e_vld = ev; t.e_err = ee; t.e_dout = ed;
    return t;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic idle;
    req_valid = 1'b0; uop = NOP; addr = '0; data_in = '0;
  endtask

  task automatic req(input logic [4:0] o, input logic [6:0] a, input logic [31:0] d);
    req_valid = 1'b1; uop = o; addr = a; data_in = d;
    tick();
    idle();
  endtask

  // Counts edges from reset release until req_ready is seen high (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 200) begin
      n++;
      tick();
      if (req_ready) break;
    end
  endtask

  int n_rdy;

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_err",   32'(rsp_err),   32'd0);
    chk("reset data_out",  data_out,       32'd0);
    reset = 1'b0;
    wait_ready(n_rdy);
    chk("first clear length", n_rdy, 32);

    tv.push_back(mk(1, STR,  7'h14, 32'hDEADBEEF, 1, 0, 32'h0));
    tv.push_back(mk(1, STR,  7'h08, 32'h12345678, 1, 0, 32'h0));
    tv.push_back(mk(1, LDR,  7'h08, 32'h0,        1, 0, 32'h12345678));
    tv.push_back(mk(1, STR,  7'h10, 32'hAABBCCDD, 1, 0, 32'h12345678));
    tv.push_back(mk(1, STRB, 7'h11, 32'hFFFFFF5A, 1, 0, 32'h12345678));
    tv.push_back(mk(1, LDRB, 7'h11, 32'h0,        1, 0, 32'h0000005A));
    tv.push_back(mk(1, LDR,  7'h10, 32'h0,        1, 0, 32'hAABB5ADD));
    tv.push_back(mk(1, LDRB, 7'h13, 32'h0,        1, 0, 32'h000000AA));
    tv.push_back(mk(1, STR,  7'h0A, 32'hFFFFFFFF, 1, 1, 32'h000000AA));
    tv.push_back(mk(1, LDR,  7'h0A, 32'h0,        1, 1, 32'h0));
    tv.push_back(mk(1, LDR,  7'h08, 32'h0,        1, 0, 32'h12345678));
    tv.push_back(mk(1, NOP,  7'h10, 32'hFFFFFFFF, 0, 0, 32'h12345678));
    tv.push_back(mk(0, LDR,  7'h10, 32'h0,        0, 0, 32'h12345678));
    tv.push_back(mk(0, STR,  7'h10, 32'h01010101, 0, 0, 32'h12345678));
    tv.push_back(mk(1, LDR,  7'h10, 32'h0,        1, 0, 32'hAABB5ADD));
    tv.push_back(mk(1, STRB, 7'h0B, 32'h00000077, 1, 0, 32'hAABB5ADD));
    tv.push_back(mk(1, LDR,  7'h08, 32'h0,        1, 0, 32'h77345678));
    tv.push_back(mk(1, LDRB, 7'h09, 32'h0,        1, 0, 32'h00000056));
    tv.push_back(mk(1, LDR,  7'h14, 32'h0,        1, 0, 32'hDEADBEEF));
    tv.push_back(mk(1, LDR,  7'h7C, 32'h0,        1, 0, 32'h0));
    tv.push_back(mk(1, STR,  7'h7C, 32'h0BADF00D, 1, 0, 32'h0));
    tv.push_back(mk(1, LDR,  7'h7C, 32'h0,        1, 0, 32'h0BADF00D));
    tv.push_back(mk(0, NOP,  7'h00, 32'h0,        0, 0, 32'h0BADF00D));

    foreach (tv[i]) begin
      req_valid = tv[i].vld; uop = tv[i].op; addr = tv[i].a; data_in = tv[i].din;
      tick();
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tv[i].e_vld));
      if (tv[i].e_vld) chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(tv[i].e_err));
      chk($sformatf("v%0d data_out", i), data_out, tv[i].e_dout);
    end
    idle();
    tick();

    // Pending load response dropped by reset; request in the reset cycle ignored.
    req_valid = 1'b1; uop = LDR; addr = 7'h14;
    tick();
    chk("pre-reset load vld",  32'(rsp_valid), 32'd1);
    chk("pre-reset load data", data_out, 32'hDEADBEEF);
    reset = 1'b1; uop = STR; data_in = 32'h11111111;
    tick();
    idle();
    chk("dropped rsp_valid",   32'(rsp_valid), 32'd0);
    chk("reset data_out",      data_out,       32'd0);
    chk("reset ready low",     32'(req_ready), 32'd0);
    reset = 1'b0;
    wait_ready(n_rdy);
    chk("pulse clear length", n_rdy, 32);
    req(LDR, 7'h14, 32'h0);
    chk("cleared word5 vld",  32'(rsp_valid), 32'd1);
    chk("cleared word5 err",  32'(rsp_err),   32'd0);
    chk("cleared word5 data", data_out,       32'd0);

    // Reset mid-clear restarts the full DEPTH-cycle sweep.
    req(STR, 7'h00, 32'hCAFEF00D);
    req(STR, 7'h7C, 32'h55AA55AA);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("mid-init ready low", 32'(req_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(n_rdy);
    chk("restart clear length", n_rdy, 32);
    req(LDR, 7'h00, 32'h0);
    chk("restart word0 data", data_out, 32'd0);
    req(LDR, 7'h7C, 32'h0);
    chk("restart word31 data", data_out, 32'd0);
    tick();
    chk("idle rsp_valid low", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
